// File: rtl/isa_pkg.sv
// Shared fetch-sequencer state and instruction-format constants for the
// instruction register, its field decoder and the multicycle controller.
package isa_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;

  localparam int DEF_BYTE_W  = 8;
  localparam int DEF_OPC_W   = 4;
  localparam int DEF_ADDR_W  = 13;
  localparam int ACC_FIELD_W = 2;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational slicing of an instruction word into its opcode, address,
// immediate-data and accumulator-select fields.
module instr_field_decode
  import isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int BYTE_W  = DEF_BYTE_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic [INSTR_W-1:0]     word_i,
  output logic [OPC_W-1:0]       opcode_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [BYTE_W-1:0]      data_o,
  output logic [ACC_FIELD_W-1:0] acc_dst_o,
  output logic [ACC_FIELD_W-1:0] acc_src_o
);

  assign opcode_o  = word_i[INSTR_W-1 -: OPC_W];
  assign addr_o    = word_i[ADDR_W-1:0];
  assign data_o    = word_i[INSTR_W-1 -: BYTE_W];
  // Accumulator selects sit directly below the opcode, destination first.
  assign acc_dst_o = word_i[INSTR_W-OPC_W-1 -: ACC_FIELD_W];
  assign acc_src_o = word_i[INSTR_W-OPC_W-1-ACC_FIELD_W -: ACC_FIELD_W];

endmodule

// File: rtl/instr_assembler.sv
// Instruction register with a byte-serial fetch sequencer: packs memory bytes
// MS-byte-first into a word and hands it to the controller via valid/ack.
module instr_assembler
  import isa_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int BYTES  = 2,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [(1<<OPC_W)-1:0] SHORT_OPC_MASK = '0,
  localparam int INSTR_W = BYTE_W * BYTES,
  localparam int IDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_start,
  input  logic                   flush,
  output logic                   byte_req,
  output logic [IDX_W-1:0]       byte_idx,
  input  logic [BYTE_W-1:0]      byte_in,
  input  logic                   byte_valid,
  output logic                   fetch_busy,
  output logic                   instr_valid,
  input  logic                   instr_ack,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [IDX_W:0]         instr_len,
  output logic [OPC_W-1:0]       opcode_out,
  output logic [ADDR_W-1:0]      addr_out,
  output logic [BYTE_W-1:0]      data_out,
  output logic [ACC_FIELD_W-1:0] acc_dst,
  output logic [ACC_FIELD_W-1:0] acc_src
);

  if (OPC_W + 2*ACC_FIELD_W > INSTR_W) begin : g_chk_acc
    $error("instr_assembler: OPC_W+4 must not exceed BYTE_W*BYTES");
  end
  if (OPC_W > BYTE_W) begin : g_chk_opc
    $error("instr_assembler: OPC_W must not exceed BYTE_W");
  end
  if (ADDR_W > INSTR_W) begin : g_chk_addr
    $error("instr_assembler: ADDR_W must not exceed INSTR_W");
  end

  fetch_state_t       state_q;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W:0]     len_q;
  logic               busy_q, valid_q;
  logic               last_byte, short_byte;

  assign last_byte  = (cnt_q == IDX_W'(BYTES-1));
  // Opcode lives in the top of byte 0, so shortness is known on its arrival.
  assign short_byte = (cnt_q == '0) && SHORT_OPC_MASK[byte_in[BYTE_W-1 -: OPC_W]];

  always_comb begin
    word_d = word_q;
    for (int i = 0; i < BYTES; i++)
      if (cnt_q == IDX_W'(i)) word_d[INSTR_W-1-i*BYTE_W -: BYTE_W] = byte_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (fetch_start) begin
          state_q <= REQ;
          word_q  <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        REQ: if (byte_valid) begin
          word_q <= word_d;
          if (last_byte || short_byte) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            len_q   <= short_byte ? (IDX_W+1)'(1) : (IDX_W+1)'(BYTES);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: if (instr_ack) begin
          valid_q <= 1'b0;
          if (fetch_start) begin
            state_q <= REQ;
            word_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_req    = busy_q;
  assign fetch_busy  = busy_q;
  assign instr_valid = valid_q;
  assign byte_idx    = cnt_q;
  assign instr_out   = word_q;
  assign instr_len   = len_q;

  instr_field_decode #(
    .INSTR_W(INSTR_W), .BYTE_W(BYTE_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W)
  ) u_dec (
    .word_i   (word_q),
    .opcode_o (opcode_out),
    .addr_o   (addr_out),
    .data_o   (data_out),
    .acc_dst_o(acc_dst),
    .acc_src_o(acc_src)
  );

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: a 2-byte instance (opcode F short) for directed
// scenarios and a 3-byte instance (opcodes 2, 8 short) for random fetches.
module tb_instr_assembler;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  // 2-byte instance
  logic a_fs = 0, a_fl = 0, a_bv = 0, a_ack = 0;
  logic [7:0] a_bin = 0;
  logic a_req, a_busy, a_vld;
  logic [0:0] a_idx;
  logic [15:0] a_out;
  logic [1:0] a_len, a_dst, a_src;
  logic [3:0] a_opc;
  logic [12:0] a_addr;
  logic [7:0] a_data;

  // 3-byte instance
  logic b_fs = 0, b_fl = 0, b_bv = 0, b_ack = 0;
  logic [7:0] b_bin = 0;
  logic b_req, b_busy, b_vld;
  logic [1:0] b_idx;
  logic [23:0] b_out;
  logic [2:0] b_len;
  logic [1:0] b_dst, b_src;
  logic [3:0] b_opc;
  logic [12:0] b_addr;
  logic [7:0] b_data;

  int n_chk = 0, n_fail = 0;

  instr_assembler #(.BYTES(2), .SHORT_OPC_MASK(16'h8000)) u_a (
    .clk(clk), .rst(rst), .fetch_start(a_fs), .flush(a_fl), .byte_req(a_req),
    .byte_idx(a_idx), .byte_in(a_bin), .byte_valid(a_bv), .fetch_busy(a_busy),
    .instr_valid(a_vld), .instr_ack(a_ack), .instr_out(a_out), .instr_len(a_len),
    .opcode_out(a_opc), .addr_out(a_addr), .data_out(a_data), .acc_dst(a_dst), .acc_src(a_src));

  instr_assembler #(.BYTES(3), .SHORT_OPC_MASK(16'h0104)) u_b (
    .clk(clk), .rst(rst), .fetch_start(b_fs), .flush(b_fl), .byte_req(b_req),
    .byte_idx(b_idx), .byte_in(b_bin), .byte_valid(b_bv), .fetch_busy(b_busy),
    .instr_valid(b_vld), .instr_ack(b_ack), .instr_out(b_out), .instr_len(b_len),
    .opcode_out(b_opc), .addr_out(b_addr), .data_out(b_data), .acc_dst(b_dst), .acc_src(b_src));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Fetch two bytes into instance A; leaves it in HOLD.
  task automatic a_fetch2(input logic [7:0] b0, input logic [7:0] b1);
    a_fs = 1; tick(); a_fs = 0;
    a_bv = 1; a_bin = b0; tick();
    a_bin = b1; tick(); a_bv = 0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", a_vld); end
    n_chk++; if (a_req !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b/%b exp 0/0", a_req, a_busy); end
    n_chk++; if (a_out !== 16'h0 || a_len !== 2'd0) begin n_fail++; $display("FAIL rst_word got %h/%0d exp 0/0", a_out, a_len); end
    n_chk++; if (b_out !== 24'h0 || b_opc !== 4'h0 || b_addr !== 13'h0) begin n_fail++; $display("FAIL rst_fields got %h/%h/%h exp 0", b_out, b_opc, b_addr); end
    rst = 0; tick();
  endtask

  task automatic test_basic();
    a_fs = 1; tick(); a_fs = 0;
    n_chk++; if (a_req !== 1'b1 || a_idx !== 1'b0) begin n_fail++; $display("FAIL basic_req0 got %b/%0d exp 1/0", a_req, a_idx); end
    a_bv = 1; a_bin = 8'h5A; tick();
    n_chk++; if (a_req !== 1'b1 || a_idx !== 1'b1 || a_vld !== 1'b0) begin n_fail++; $display("FAIL basic_req1 got %b/%0d/%b exp 1/1/0", a_req, a_idx, a_vld); end
    a_bin = 8'h3C; tick(); a_bv = 0;
    n_chk++; if (a_vld !== 1'b1 || a_out !== 16'h5A3C) begin n_fail++; $display("FAIL basic_word got %b/%h exp 1/5a3c", a_vld, a_out); end
    n_chk++; if (a_opc !== 4'h5 || a_dst !== 2'd2 || a_src !== 2'd2) begin n_fail++; $display("FAIL basic_fields got %h/%0d/%0d exp 5/2/2", a_opc, a_dst, a_src); end
    n_chk++; if (a_addr !== 13'h1A3C || a_data !== 8'h5A || a_len !== 2'd2) begin n_fail++; $display("FAIL basic_addr got %h/%h/%0d exp 1a3c/5a/2", a_addr, a_data, a_len); end
    repeat (3) tick();
    n_chk++; if (a_vld !== 1'b1 || a_out !== 16'h5A3C || a_req !== 1'b0) begin n_fail++; $display("FAIL basic_hold got %b/%h/%b exp 1/5a3c/0", a_vld, a_out, a_req); end
    a_ack = 1; tick(); a_ack = 0;
    n_chk++; if (a_vld !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_ack got %b/%b exp 0/0", a_vld, a_busy); end
  endtask

  task automatic test_short();
    a_fs = 1; tick(); a_fs = 0;
    a_bv = 1; a_bin = 8'hF3; tick(); a_bv = 0;
    n_chk++; if (a_vld !== 1'b1 || a_out !== 16'hF300 || a_len !== 2'd1) begin n_fail++; $display("FAIL short_word got %b/%h/%0d exp 1/f300/1", a_vld, a_out, a_len); end
    n_chk++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL short_req got %b exp 0", a_req); end
    a_ack = 1; tick(); a_ack = 0;
  endtask

  task automatic test_back_to_back();
    a_fetch2(8'h5A, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      a_bv = 1; a_bin = 8'($urandom); a_fs = i[0]; tick();
      n_chk++; if (a_vld !== 1'b1 || a_out !== 16'h5A3C || a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_hold%0d got %b/%h/%b exp 1/5a3c/0", i, a_vld, a_out, a_busy); end
    end
    a_bv = 0; a_ack = 1; a_fs = 1; tick(); a_ack = 0; a_fs = 0;
    n_chk++; if (a_busy !== 1'b1 || a_vld !== 1'b0 || a_out !== 16'h0) begin n_fail++; $display("FAIL b2b_restart got %b/%b/%h exp 1/0/0", a_busy, a_vld, a_out); end
    a_bv = 1; a_bin = 8'h12; tick(); a_bin = 8'h34; tick(); a_bv = 0;
    n_chk++; if (a_vld !== 1'b1 || a_out !== 16'h1234) begin n_fail++; $display("FAIL b2b_word got %b/%h exp 1/1234", a_vld, a_out); end
    a_ack = 1; tick(); a_ack = 0;
  endtask

  task automatic test_abort();
    a_fs = 1; tick(); a_fs = 0;
    a_bv = 1; a_bin = 8'hAB; tick(); a_bv = 0;
    #2 rst = 1; #1;
    n_chk++; if (a_req !== 1'b0 || a_idx !== 1'b0 || a_out !== 16'h0 || a_vld !== 1'b0) begin n_fail++; $display("FAIL arst got %b/%0d/%h/%b exp 0", a_req, a_idx, a_out, a_vld); end
    #3 rst = 0; tick();
    a_fs = 1; tick(); a_fs = 0;
    a_bv = 1; a_bin = 8'hAB; tick(); a_bv = 0;
    a_fl = 1; tick(); a_fl = 0;
    n_chk++; if (a_busy !== 1'b0 || a_vld !== 1'b0 || a_out !== 16'h0 || a_len !== 2'd0) begin n_fail++; $display("FAIL flush got %b/%b/%h/%0d exp 0", a_busy, a_vld, a_out, a_len); end
    a_fl = 1; a_fs = 1; tick(); a_fl = 0; a_fs = 0;
    n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL flush_prio got %b exp 0", a_busy); end
    a_fetch2(8'h77, 8'h88);
    n_chk++; if (a_vld !== 1'b1 || a_out !== 16'h7788) begin n_fail++; $display("FAIL flush_refetch got %b/%h exp 1/7788", a_vld, a_out); end
    a_fl = 1; tick(); a_fl = 0;
    n_chk++; if (a_vld !== 1'b0 || a_out !== 16'h0) begin n_fail++; $display("FAIL flush_hold got %b/%h exp 0/0", a_vld, a_out); end
  endtask

  task automatic test_bytes3();
    b_fs = 1; tick(); b_fs = 0;
    b_bv = 1; b_bin = 8'h12; tick(); b_bv = 0; tick();
    b_bv = 1; b_bin = 8'h34; tick(); b_bv = 0; repeat (2) tick();
    n_chk++; if (b_idx !== 2'd2 || b_req !== 1'b1) begin n_fail++; $display("FAIL b3_idx got %0d/%b exp 2/1", b_idx, b_req); end
    b_bv = 1; b_bin = 8'h56; tick(); b_bv = 0;
    n_chk++; if (b_vld !== 1'b1 || b_out !== 24'h123456 || b_len !== 3'd3) begin n_fail++; $display("FAIL b3_word got %b/%h/%0d exp 1/123456/3", b_vld, b_out, b_len); end
    n_chk++; if (b_opc !== 4'h1 || b_addr !== 13'h1456 || b_data !== 8'h12 || b_dst !== 2'd0 || b_src !== 2'd2) begin n_fail++; $display("FAIL b3_fields got %h/%h/%h/%0d/%0d exp 1/1456/12/0/2", b_opc, b_addr, b_data, b_dst, b_src); end
    b_ack = 1; tick(); b_ack = 0;
  endtask

  task automatic test_random();
    logic [7:0] bytes [3];
    logic [23:0] exp_word;
    int exp_len, k, cyc;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bytes[0][7:4] = ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h8;
      exp_len = (bytes[0][7:4] == 4'h2 || bytes[0][7:4] == 4'h8) ? 1 : 3;
      exp_word = 24'h0;
      for (int i = 0; i < exp_len; i++) exp_word = exp_word | (24'(bytes[i]) << (16 - 8*i));
      b_fs = 1; tick(); b_fs = 0;
      k = 0; cyc = 0;
      while (!b_vld && cyc < 60) begin
        if (b_req && $urandom_range(0, 2) != 0) begin
          n_chk++; if (b_idx !== 2'(k)) begin n_fail++; $display("FAIL rnd%0d_idx got %0d exp %0d", t, b_idx, k); end
          b_bv = 1; b_bin = bytes[k]; tick(); k++;
        end else begin
          b_bv = 0; b_bin = 8'($urandom); tick();
        end
        b_bv = 0; cyc++;
      end
      n_chk++;
      if (!b_vld) begin n_fail++; $display("FAIL rnd%0d_timeout got valid %b exp 1", t, b_vld); end
      else if (b_out !== exp_word || b_len !== 3'(exp_len) || k != exp_len) begin
        n_fail++; $display("FAIL rnd%0d_word got %h/%0d/%0d exp %h/%0d", t, b_out, b_len, k, exp_word, exp_len);
      end
      n_chk++; if (b_opc !== exp_word[23:20] || b_addr !== exp_word[12:0]) begin n_fail++; $display("FAIL rnd%0d_fields got %h/%h exp %h/%h", t, b_opc, b_addr, exp_word[23:20], exp_word[12:0]); end
      b_ack = 1; tick(); b_ack = 0;
      if ($urandom_range(0, 1) != 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_back_to_back();
    test_abort();
    test_bytes3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
